// File: rtl/stop_watch_lap_buf.sv
// mm:ss.cc stopwatch with debounced buttons, a circular lap buffer and a lap review mode.
// Optional AUTO_RANGE_EN: show ss.cc on the display while the shown time is below one minute.
module stop_watch_lap_buf #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int LAP_DEPTH     = 4,
  parameter int DEBOUNCE_BITS = 17,
  localparam int LCW          = $clog2(LAP_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      btn,
  output logic [15:0]     value,
  output logic [3:0]      dp_mask,
  output logic [23:0]     time_bcd,
  output logic            running,
  output logic            review,
  output logic            overflow,
  output logic [LCW-1:0]  lap_count,
  output logic [LCW-1:0]  lap_sel
);

  localparam int PRE_MAX = CLK_FREQ_HZ / 100 - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int PW      = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [23:0] TIME_MAX = 24'h595999;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP, ST_REVIEW} state_t;

  logic [2:0]               sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DEBOUNCE_BITS-1:0] div_q, div_d;
  logic [2:0]               smp_q, smp_d, lvl_q, lvl_d, lvl_dly_q, lvl_dly_d;
  state_t                   state_q, state_d;
  logic [PRE_W-1:0]         pre_q, pre_d;
  logic [23:0]              time_q, time_d;
  logic                     ovf_q, ovf_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rev_ptr_q, rev_ptr_d;
  logic [LCW-1:0]           cnt_q, cnt_d, sel_q, sel_d;
  logic [15:0]              value_q, value_d;
  logic [3:0]               dp_q, dp_d;
  logic                     running_q, running_d, review_q, review_d;

  logic [23:0] lap_mem [LAP_DEPTH];
  logic [23:0] lap_rd;
  logic [23:0] src;
  logic        lap_we;
  logic        strobe, tick, sat;
  logic [2:0]  agree, pulse;
  logic        do_clr, do_start, do_lap, go_idle;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LAP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(LAP_DEPTH - 1) : p - 1'b1;
  endfunction

  // Ripple a +1 through c1,c10,s1,s10,m1,m10; tens of seconds/minutes wrap at 5.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (lap_we) begin
      lap_mem[wr_ptr_q] <= time_q;
    end
  end

  assign lap_rd = lap_mem[rev_ptr_q];

  // Debounce: a level is accepted once two consecutive samples agree.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    div_d     = div_q + 1'b1;
    strobe    = &div_q;
    agree     = ~(sync2_q ^ smp_q);
    smp_d     = strobe ? sync2_q : smp_q;
    lvl_d     = strobe ? ((agree & sync2_q) | (~agree & lvl_q)) : lvl_q;
    lvl_dly_d = lvl_q;
    pulse     = lvl_q & ~lvl_dly_q;
    do_clr    = pulse[2];
    do_start  = pulse[0] & ~pulse[2];
    do_lap    = pulse[1] & ~pulse[2] & ~pulse[0];
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    time_d    = time_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rev_ptr_d = rev_ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    lap_we    = 1'b0;
    go_idle   = 1'b0;
    sat       = (time_q == TIME_MAX);
    tick      = (state_q == ST_RUN) && (pre_q == PRE_W'(PRE_MAX));

    if (state_q == ST_RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (do_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (do_lap) begin
          lap_we   = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          if (cnt_q != LCW'(LAP_DEPTH)) cnt_d = cnt_q + 1'b1;
        end
        if (tick) begin
          if (sat) begin
            ovf_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            time_d = bcd_inc(time_q);
          end
        end
        if (do_start) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (do_clr) begin
          go_idle = 1'b1;
        end else if (do_start) begin
          if (!ovf_q) state_d = ST_RUN;
        end else if (do_lap && cnt_q != '0) begin
          state_d   = ST_REVIEW;
          sel_d     = cnt_q;
          rev_ptr_d = ptr_dec(wr_ptr_q);
        end
      end
      ST_REVIEW: begin
        if (do_clr) begin
          go_idle = 1'b1;
        end else if (do_start) begin
          if (!ovf_q) begin
            state_d = ST_RUN;
            sel_d   = '0;
          end
        end else if (do_lap) begin
          if (sel_q == LCW'(1)) begin
            state_d = ST_STOP;
            sel_d   = '0;
          end else begin
            sel_d     = sel_q - 1'b1;
            rev_ptr_d = ptr_dec(rev_ptr_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_idle) begin
      state_d  = ST_IDLE;
      pre_d    = '0;
      time_d   = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      sel_d    = '0;
    end
  end

  // Display follows the registered source, so value trails it by one clock.
  always_comb begin
    src     = (state_q == ST_REVIEW) ? lap_rd : time_q;
    value_d = src[23:8];
`ifdef AUTO_RANGE_EN
    if (src[23:16] == 8'h00) value_d = src[15:0];
`endif
    dp_d      = 4'b0100;
    running_d = (state_d == ST_RUN);
    review_d  = (state_d == ST_REVIEW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= '0;
      smp_q     <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      time_q    <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rev_ptr_q <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      value_q   <= '0;
      dp_q      <= '0;
      running_q <= 1'b0;
      review_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      smp_q     <= smp_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      state_q   <= state_d;
      pre_q     <= pre_d;
      time_q    <= time_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rev_ptr_q <= rev_ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      value_q   <= value_d;
      dp_q      <= dp_d;
      running_q <= running_d;
      review_q  <= review_d;
    end
  end

  assign value     = value_q;
  assign dp_mask   = dp_q;
  assign time_bcd  = time_q;
  assign running   = running_q;
  assign review    = review_q;
  assign overflow  = ovf_q;
  assign lap_count = cnt_q;
  assign lap_sel   = sel_q;

endmodule

// File: tb/tb_stop_watch_lap_buf.sv
// Randomized bench for stop_watch_lap_buf against a centisecond/queue reference model.
module tb_stop_watch_lap_buf;

  localparam int DEPTH     = 4;
  localparam int LCW       = $clog2(DEPTH + 1);
  localparam int TICK_CLKS = 10;
  localparam int MAX_CS    = 359999;
  localparam int HOLD      = 24;
  localparam int GAP       = 24;

  typedef enum int {M_IDLE, M_RUN, M_STOP, M_REV} mst_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [2:0]     btn = 3'b000;
  logic [15:0]    value;
  logic [3:0]     dp_mask;
  logic [23:0]    time_bcd;
  logic           running, review, overflow;
  logic [LCW-1:0] lap_count, lap_sel;

  stop_watch_lap_buf #(
    .CLK_FREQ_HZ  (1000),
    .LAP_DEPTH    (DEPTH),
    .DEBOUNCE_BITS(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn),
    .value    (value),
    .dp_mask  (dp_mask),
    .time_bcd (time_bcd),
    .running  (running),
    .review   (review),
    .overflow (overflow),
    .lap_count(lap_count),
    .lap_sel  (lap_sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  mst_t        m_st;
  int          m_cs, m_pre, m_sel;
  bit          m_ovf;
  int          m_laps[$];
  logic [15:0] m_value;
  logic [3:0]  m_dp;

  int   cyc = 0;
  int   lat = 0;
  int   cal_phase = 0;
  bit   chk_en = 1'b0;
  bit   pend_valid = 1'b0;
  int   pend_edge = 0;
  logic [2:0] pend_mask = 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [15:0] disp(input int cs);
    logic [23:0] b;
    b = to_bcd(cs);
`ifdef AUTO_RANGE_EN
    if (cs < 6000) return b[15:0];
`endif
    return b[23:8];
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cs = 0; m_pre = 0; m_sel = 0; m_ovf = 1'b0;
    m_laps.delete();
    m_value = '0; m_dp = '0;
  endtask

  // One clock edge of the reference model; a[] holds the button pulses acting on this edge.
  task automatic model_step(input logic [2:0] a);
    bit   clr, sta, lp, tick;
    int   src;
    mst_t nst;
    src     = (m_st == M_REV) ? m_laps[m_sel-1] : m_cs;
    m_value = disp(src);
    m_dp    = 4'b0100;
    clr  = a[2];
    sta  = a[0] && !clr;
    lp   = a[1] && !clr && !a[0];
    tick = (m_st == M_RUN) && (m_pre == TICK_CLKS - 1);
    if (m_st == M_RUN) m_pre = (m_pre + 1) % TICK_CLKS;
    nst = m_st;
    case (m_st)
      M_IDLE: if (sta) nst = M_RUN;
      M_RUN: begin
        if (lp) begin
          m_laps.push_back(m_cs);
          if (m_laps.size() > DEPTH) void'(m_laps.pop_front());
        end
        if (tick) begin
          if (m_cs == MAX_CS) begin m_ovf = 1'b1; nst = M_STOP; end
          else m_cs++;
        end
        if (sta) nst = M_STOP;
      end
      M_STOP: begin
        if (clr) nst = M_IDLE;
        else if (sta) begin if (!m_ovf) nst = M_RUN; end
        else if (lp && m_laps.size() > 0) begin nst = M_REV; m_sel = m_laps.size(); end
      end
      M_REV: begin
        if (clr) nst = M_IDLE;
        else if (sta) begin if (!m_ovf) begin nst = M_RUN; m_sel = 0; end end
        else if (lp) begin
          if (m_sel == 1) begin nst = M_STOP; m_sel = 0; end
          else m_sel--;
        end
      end
      default: nst = M_IDLE;
    endcase
    if (nst == M_IDLE && m_st != M_IDLE) begin
      m_cs = 0; m_pre = 0; m_sel = 0; m_ovf = 1'b0;
      m_laps.delete();
    end
    m_st = nst;
  endtask

  task automatic check_all();
    check_eq("time_bcd",  32'(time_bcd),  32'(to_bcd(m_cs)));
    check_eq("running",   32'(running),   32'(m_st == M_RUN));
    check_eq("review",    32'(review),    32'(m_st == M_REV));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
    check_eq("lap_count", 32'(lap_count), 32'(m_laps.size()));
    check_eq("lap_sel",   32'(lap_sel),   32'(m_sel));
    check_eq("value",     32'(value),     32'(m_value));
    check_eq("dp_mask",   32'(dp_mask),   32'(m_dp));
  endtask

  task automatic step();
    logic [2:0] act;
    @(posedge clk);
    cyc++;
    act = 3'b000;
    if (pend_valid && cyc == pend_edge) begin
      act = pend_mask;
      pend_valid = 1'b0;
    end
    model_step(act);
    @(negedge clk);
    if (chk_en) check_all();
  endtask

  task automatic press(input logic [2:0] mask);
    while (cyc % 4 != cal_phase) step();
    btn        = mask;
    pend_mask  = mask;
    pend_edge  = cyc + lat;
    pend_valid = 1'b1;
    repeat (HOLD) step();
    btn = 3'b000;
    repeat (GAP) step();
    $display("[TB] press %b at cycle %0d -> cs=%0d laps=%0d sel=%0d", mask, pend_edge, m_cs, m_laps.size(), m_sel);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_time"},  32'(time_bcd),  32'h0);
    check_eq({tag, "_run"},   32'(running),   32'h0);
    check_eq({tag, "_rev"},   32'(review),    32'h0);
    check_eq({tag, "_ovf"},   32'(overflow),  32'h0);
    check_eq({tag, "_lcnt"},  32'(lap_count), 32'h0);
    check_eq({tag, "_lsel"},  32'(lap_sel),   32'h0);
    check_eq({tag, "_value"}, 32'(value),     32'h0);
    check_eq({tag, "_dp"},    32'(dp_mask),   32'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m0, r;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    chk_en = 1'b1;
    repeat (3) step();

    // Calibrate button-to-action latency with the first start press.
    n0 = cyc;
    cal_phase = n0 % 4;
    btn = 3'b001;
    chk_en = 1'b0;
    for (int k = 0; k < 40 && !running; k++) step();
    if (!running) begin
      $display("FAIL cal_start: running never rose, got 0 expected 1");
      $fatal(1, "no start response");
    end
    m0  = cyc;
    lat = m0 - n0;
    check_eq("cal_latency_ok", 32'(lat <= 20), 32'h1);
    m_st = M_RUN;
    chk_en = 1'b1;
    check_all();
    while (cyc < n0 + HOLD) step();
    btn = 3'b000;
    repeat (GAP) step();

    // 1000 running clocks -> one second
    while (cyc < m0 + 1000) step();
    check_eq("t1_time", 32'(time_bcd), 32'h000100);
    check_eq("t1_running", 32'(running), 32'h1);
    step();
    check_eq("t1_value", 32'(value), 32'h0001);

    // Two laps, then review them
    press(3'b001);
    press(3'b100);
    check_eq("t2_clear_lcnt", 32'(lap_count), 32'h0);
    check_eq("t2_clear_time", 32'(time_bcd), 32'h0);
    press(3'b001);
    while (m_cs < 35) step();
    press(3'b010);
    while (m_cs < 50) step();
    press(3'b010);
    press(3'b001);
    check_eq("t2_lcnt", 32'(lap_count), 32'h2);
    press(3'b010);
    check_eq("t2_sel2", 32'(lap_sel), 32'h2);
    check_eq("t2_rev2", 32'(review), 32'h1);
    check_eq("t2_val2", 32'(value), 32'h0000);
    press(3'b010);
    check_eq("t2_sel1", 32'(lap_sel), 32'h1);
    press(3'b010);
    check_eq("t2_sel0", 32'(lap_sel), 32'h0);
    check_eq("t2_rev0", 32'(review), 32'h0);
    check_eq("t2_stop", 32'(running), 32'h0);

    // Five laps into a four-entry buffer
    press(3'b100);
    press(3'b001);
    for (int k = 0; k < 5; k++) begin
      repeat (300) step();
      press(3'b010);
    end
    press(3'b001);
    check_eq("t3_lcnt", 32'(lap_count), 32'h4);
    for (int k = 4; k >= 1; k--) begin
      press(3'b010);
      check_eq("t3_sel", 32'(lap_sel), 32'(k));
    end
    press(3'b010);
    check_eq("t3_back_stop", 32'(review), 32'h0);

    // Simultaneous buttons in STOP, then clear while running
    press(3'b111);
    check_eq("t5_idle_lcnt", 32'(lap_count), 32'h0);
    check_eq("t5_idle_run", 32'(running), 32'h0);
    press(3'b001);
    press(3'b100);
    check_eq("t5_clr_in_run", 32'(running), 32'h1);

    // Asynchronous reset in the middle of a run
    press(3'b010);
    press(3'b010);
    check_eq("t6_lcnt", 32'(lap_count), 32'h2);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("t6");
    model_reset();
    pend_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    repeat (3) step();

    // Saturation from a preloaded 59:59.98
    force dut.time_q = 24'h595998;
    m_cs = 359998;
    step();
    release dut.time_q;
    press(3'b001);
    check_eq("t4_time", 32'(time_bcd), 32'h595999);
    check_eq("t4_ovf", 32'(overflow), 32'h1);
    check_eq("t4_run", 32'(running), 32'h0);
    press(3'b001);
    check_eq("t4_start_ignored", 32'(running), 32'h0);
    press(3'b100);
    check_eq("t4_clr_time", 32'(time_bcd), 32'h0);
    check_eq("t4_clr_ovf", 32'(overflow), 32'h0);

    // Random button traffic
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       press(3'b001);
      else if (r < 8)  press(3'b010);
      else if (r == 8) press(3'b100);
      else             press(3'($urandom_range(1, 7)));
      repeat ($urandom_range(0, 200)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stop_watch_lap_buf.md
Name: stop_watch_lap_buf

Overview:
Parametrised successor to the minute/second stopwatch, built around a mm:ss.cc (centisecond) BCD time core. It adds a circular lap buffer of LAP_DEPTH entries, a clear button and a review mode for stepping through stored laps. Raw buttons are debounced and edge-detected internally. Drives the existing 4-digit FND controller through a 16-bit BCD value and a decimal-point mask.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; the centisecond tick period is CLK_FREQ_HZ/100 clocks.
LAP_DEPTH, 4, number of lap entries (>=1).
DEBOUNCE_BITS, 17, button sample period is 2^DEBOUNCE_BITS clocks.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
btn  in  3  raw buttons, active-high: [0] start/stop, [1] lap, [2] clear
value  out  16  BCD digits to the FND controller, {d3,d2,d1,d0}
dp_mask  out  4  decimal-point enables, bit i is digit i
time_bcd  out  24  live time {m10,m1,s10,s1,c10,c1}
running  out  1  1 in RUN
review  out  1  1 in REVIEW
overflow  out  1  sticky 59:59.99 saturation flag
lap_count  out  LCW  stored laps, 0..LAP_DEPTH; LCW = $clog2(LAP_DEPTH+1)
lap_sel  out  LCW  1-based index of the displayed lap (1 = oldest); 0 when showing live time

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, state IDLE, buffer empty, prescaler 0, debouncers 0.
- Debounce: each btn bit is sampled every 2^DEBOUNCE_BITS clocks. The level is accepted after 2 equal consecutive samples. A rising edge of the accepted level gives a 1-clock pulse (start_p, lap_p, clr_p).
- Same-cycle priority: clear > start > lap. Only the highest-priority pulse acts.
- States: IDLE, RUN, STOP, REVIEW.
  - IDLE: start -> RUN.
  - RUN: start -> STOP; lap -> store the lap, stay in RUN; clear ignored.
  - STOP: start -> RUN (resume); clear -> IDLE; lap -> REVIEW with lap_sel = lap_count if lap_count > 0, otherwise ignored.
  - REVIEW: lap -> lap_sel-1; when lap_sel = 1, lap -> STOP with lap_sel = 0. start -> RUN with lap_sel = 0. clear -> IDLE.
- Entering IDLE: time, prescaler, buffer, lap_count, lap_sel and overflow all cleared.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ/100-1 only in RUN and holds otherwise, so a resume keeps the fractional tick.
  - A tick is issued on the terminal count.
  - A tick in the same cycle as the RUN->STOP transition is still counted, because the state is registered.
- Time core: c1, c10, s1, s10 (0..5), m1, m10 (0..5). BCD carry chain, all updated in the tick cycle.
- Saturation: a tick at 59:59.99 holds the time, sets overflow=1 and moves to STOP. overflow is cleared only by clear or reset. start while overflow=1 is ignored.
- Lap store:
  - Writes time_bcd as registered before the same-cycle increment.
  - Write pointer wraps modulo LAP_DEPTH.
  - When full, the oldest entry is overwritten, the oldest pointer advances and lap_count stays at LAP_DEPTH.
  - lap_count is visible 1 clock after lap_p.
- Display source: the stored entry lap_sel when review=1, otherwise time_bcd.
  - value = {m10,m1,s10,s1}.
  - dp_mask = 4'b0100 (separator after minutes).
- All outputs are registered. value lags its source by 1 clock.

Optional Feature:
AUTO_RANGE_EN.
- Defined: while the displayed source has m10 = m1 = 0, value = {s10,s1,c10,c1} and dp_mask = 4'b0100. Otherwise the mm:ss format applies.
- Not defined: the display is always mm:ss and centiseconds appear only on time_bcd.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000 (tick every 10 clocks) and DEBOUNCE_BITS=2.
1. Reset, press start, run 1000 clocks -> time_bcd=24'h000100, running=1, value=16'h0001.
2. Run to 00:00.37, press lap; press lap again at 00:00.52; press start; press lap three times -> lap_count=2, review shows 16'h0000 with lap_sel=2 then lap_sel=1, third lap returns to STOP with lap_sel=0.
3. With LAP_DEPTH=4, store 5 laps at known times -> lap_count=4; review from lap_sel=4 down to 1 shows laps 5..2; lap 1 is gone.
4. Preload near 59:59.98 by running, let 2 ticks pass -> time_bcd=24'h595999, overflow=1, running=0; start ignored; clear -> all zero, overflow=0, IDLE.
5. Start, clear and lap pulses in the same cycle while in STOP -> IDLE (clear wins). Clear pressed during RUN -> no effect.
6. Deassert reset_n mid-RUN with laps stored -> all outputs 0 immediately, lap_count=0. With AUTO_RANGE_EN at 00:12.34 -> value=16'h1234.
